// File: rtl/ser_reg_ctrl.sv
// rtl/ser_reg_ctrl.sv - serial frame controller driving one-hot loads into the L0-L3 nibble register bank
module ser_reg_ctrl #(
    parameter int DW = 4
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          serIn,
    input  logic          Zero,
    output logic [DW-1:0] dOut,
    output logic [3:0]    ld,
    output logic          clrAll,
    output logic          busy,
    output logic          done,
    output logic          frmErr
);

    localparam int CW = $clog2(DW + 1);
    localparam logic [CW-1:0] LAST_DATA = CW'(DW - 1);
    localparam logic [CW-1:0] LAST_ADDR = CW'(1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    addr_q, addr_d;
    logic [DW-1:0] data_q, data_d;
    logic [3:0]    ld_q, ld_d;
    logic          done_q, done_d;
    logic          frm_err_q, frm_err_d;
    logic          clr_q, clr_d;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            ld_q      <= '0;
            done_q    <= 1'b0;
            frm_err_q <= 1'b0;
            clr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            ld_q      <= ld_d;
            done_q    <= done_d;
            frm_err_q <= frm_err_d;
            clr_q     <= clr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        data_d    = data_q;
        ld_d      = '0;
        done_d    = 1'b0;
        frm_err_d = 1'b0;
        clr_d     = 1'b0;

        // Clear request overrides everything, including a stop-bit load or a start bit.
        if (Zero) begin
            clr_d   = 1'b1;
            state_d = IDLE;
            cnt_d   = '0;
            addr_d  = '0;
            data_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!serIn) begin
                        state_d = ADDR;
                        cnt_d   = '0;
                    end
                end
                ADDR: begin
                    addr_d = {addr_q[0], serIn};
                    if (cnt_q == LAST_ADDR) begin
                        state_d = DATA;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    data_d = {data_q[DW-2:0], serIn};
                    if (cnt_q == LAST_DATA) begin
                        state_d = STOP;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                STOP: begin
                    if (serIn) begin
                        ld_d    = 4'b0001 << addr_q;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        frm_err_d = 1'b1;
                        state_d   = BREAK;
                    end
                    cnt_d = '0;
                end
                BREAK: begin
                    // A held-low line must return high before a new start is accepted.
                    if (serIn) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign dOut   = data_q;
    assign ld     = ld_q;
    assign done   = done_q;
    assign frmErr = frm_err_q;
    assign clrAll = clr_q;
    assign busy   = (state_q != IDLE);

endmodule
